// File: rtl/alarm_pkg.sv
// Shared encodings and reset defaults for the alarm countdown timer.
package alarm_pkg;

    localparam logic [1:0] INT_ARM  = 2'd0;
    localparam logic [1:0] INT_DRV  = 2'd1;
    localparam logic [1:0] INT_PASS = 2'd2;
    localparam logic [1:0] INT_ON   = 2'd3;

    localparam int unsigned NUM_TIMES    = 4;
    localparam int unsigned CLK_DIV_DEF  = 100;
    localparam int unsigned T_ARM_DEF_C  = 6;
    localparam int unsigned T_DRV_DEF_C  = 8;
    localparam int unsigned T_PASS_DEF_C = 15;
    localparam int unsigned T_ON_DEF_C   = 10;

    typedef enum logic {
        StIdle  = 1'b0,
        StCount = 1'b1
    } cnt_state_e;

    function automatic logic [3:0] default_time(
        input logic [1:0]  idx,
        input int unsigned t_arm,
        input int unsigned t_drv,
        input int unsigned t_pass,
        input int unsigned t_on
    );
        logic [3:0] val;
        unique case (idx)
            INT_ARM:  val = 4'(t_arm);
            INT_DRV:  val = 4'(t_drv);
            INT_PASS: val = 4'(t_pass);
            INT_ON:   val = 4'(t_on);
            default:  val = 4'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/one_hz_gen.sv
// One-second prescaler: wraps every CLK_DIV cycles, emits a one-cycle tick on the last
// count and a 50% duty one_hz_enable. clear restarts the second from zero.
module one_hz_gen #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic one_hz_enable
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2);

    logic [PW-1:0] presc_q, presc_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (clear || presc_q == LAST) begin
            presc_d = '0;
        end
    end

    always_comb begin
        tick          = (presc_q == LAST);
        one_hz_enable = (presc_q >= HALF);
    end

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Alarm countdown timer: four programmable second counts, one active countdown at a time.
// Optional `remaining` output is built only when ALARM_TIMER_REMAIN_EN is defined.
module alarm_timer_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned T_ARM_DEF  = T_ARM_DEF_C,
    parameter int unsigned T_DRV_DEF  = T_DRV_DEF_C,
    parameter int unsigned T_PASS_DEF = T_PASS_DEF_C,
    parameter int unsigned T_ON_DEF   = T_ON_DEF_C
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] interval,
    input  logic       start_timer,
    input  logic       prog_we,
    input  logic [1:0] prog_sel,
    input  logic [3:0] prog_val,
    output logic       expired,
    output logic       one_hz_enable,
    output logic       busy
`ifdef ALARM_TIMER_REMAIN_EN
   ,output logic [3:0] remaining
`endif
);

    cnt_state_e state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       expired_q, expired_d;
    logic [3:0] time_q [NUM_TIMES];
    logic [3:0] time_d [NUM_TIMES];
    logic       start_accept;
    logic       tick;
    logic [3:0] load_val;

    // A write in the same cycle suppresses the start entirely, including the prescaler clear.
    assign start_accept = start_timer & ~prog_we;
    assign load_val     = time_q[interval];

    one_hz_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_one_hz_gen (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_accept),
        .tick         (tick),
        .one_hz_enable(one_hz_enable)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (prog_we) begin
            state_d = StIdle;
        end else if (start_accept) begin
            // A zero load expires on the start edge itself, so there is nothing to count.
            state_d = (load_val == 4'd0) ? StIdle : StCount;
        end else if (state_q == StCount && tick && count_q == 4'd1) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= 4'd0;
            expired_q <= 1'b0;
            for (int i = 0; i < NUM_TIMES; i++) begin
                time_q[i] <= default_time(2'(i), T_ARM_DEF, T_DRV_DEF, T_PASS_DEF, T_ON_DEF);
            end
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
            time_q    <= time_d;
        end
    end

    always_comb begin
        time_d    = time_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (prog_we) begin
            time_d[prog_sel] = prog_val;
            count_d          = 4'd0;
        end else if (start_accept) begin
            count_d   = load_val;
            expired_d = (load_val == 4'd0);
        end else if (state_q == StCount && tick) begin
            count_d   = count_q - 4'd1;
            expired_d = (count_q == 4'd1);
        end
    end

    always_comb begin
        busy    = (state_q == StCount);
        expired = expired_q;
    end

`ifdef ALARM_TIMER_REMAIN_EN
    always_comb begin
        remaining = (state_q == StCount) ? count_q : 4'd0;
    end
`endif

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Directed scenarios plus random traffic for alarm_timer_ctrl, checked every cycle against
// a deadline-based reference model.
module tb_alarm_timer_ctrl;

    localparam int CD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] interval;
    logic       start_timer;
    logic       prog_we;
    logic [1:0] prog_sel;
    logic [3:0] prog_val;
    logic       expired;
    logic       one_hz_enable;
    logic       busy;
`ifdef ALARM_TIMER_REMAIN_EN
    logic [3:0] remaining;
`endif

    always #5 clock = ~clock;

    alarm_timer_ctrl #(
        .CLK_DIV(CD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .interval     (interval),
        .start_timer  (start_timer),
        .prog_we      (prog_we),
        .prog_sel     (prog_sel),
        .prog_val     (prog_val),
        .expired      (expired),
        .one_hz_enable(one_hz_enable),
        .busy         (busy)
`ifdef ALARM_TIMER_REMAIN_EN
       ,.remaining    (remaining)
`endif
    );

    // Model: times, edge index since reset, edge of last accepted start, and expiry deadline.
    int m_reg [4];
    bit m_active;
    int m_e, m_base, m_start, m_n, m_exp;
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_reg    = '{6, 8, 15, 10};
        m_active = 1'b0;
        m_e      = 0;
        m_base   = 0;
        m_start  = 0;
        m_n      = 0;
        m_exp    = -1;
    endtask

    task automatic check_outputs();
        chk("expired", {31'd0, expired}, {31'd0, (m_e == m_exp)});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("one_hz", {31'd0, one_hz_enable}, {31'd0, (((m_e - m_base) % CD) >= CD / 2)});
`ifdef ALARM_TIMER_REMAIN_EN
        chk("remaining", {28'd0, remaining},
            m_active ? 32'(m_n - (m_e - m_start) / CD) : 32'd0);
`endif
    endtask

    task automatic step(input bit st, input logic [1:0] iv, input bit we,
                        input logic [1:0] sel, input logic [3:0] val);
        start_timer = st;
        interval    = iv;
        prog_we     = we;
        prog_sel    = sel;
        prog_val    = val;
        @(posedge clock);
        m_e++;
        if (we) begin
            m_reg[sel] = int'(val);
            m_active   = 1'b0;
            m_exp      = -1;
        end else if (st) begin
            m_base  = m_e;
            m_start = m_e;
            m_n     = m_reg[iv];
            if (m_n == 0) begin
                m_active = 1'b0;
                m_exp    = m_e;
            end else begin
                m_active = 1'b1;
                m_exp    = m_e + m_n * CD;
            end
        end else if (m_active && m_e == m_exp) begin
            m_active = 1'b0;
        end
        #1;
        start_timer = 1'b0;
        prog_we     = 1'b0;
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic run_until_expired(output int k);
        k = 0;
        do begin
            idle(1);
            k++;
        end while (!expired && k < 200);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_expired", {31'd0, expired}, 32'd0);
        chk("rst_one_hz", {31'd0, one_hz_enable}, 32'd0);
`ifdef ALARM_TIMER_REMAIN_EN
        chk("rst_remaining", {28'd0, remaining}, 32'd0);
`endif
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    int k;

    initial begin
        reset       = 1'b1;
        start_timer = 1'b0;
        prog_we     = 1'b0;
        interval    = 2'd0;
        prog_sel    = 2'd0;
        prog_val    = 4'd0;
        repeat (2) @(negedge clock);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_expired", {31'd0, expired}, 32'd0);
        chk("init_one_hz", {31'd0, one_hz_enable}, 32'd0);
        reset = 1'b0;
        model_reset();
        idle(3);

        // Scenario 1: driver delay, 8 s at 4 cycles per second.
        step(1'b1, 2'd1, 1'b0, 2'd0, 4'd0);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        run_until_expired(k);
        chk("s1_latency", k, 32);
        idle(1);
        chk("s1_idle", {31'd0, busy}, 32'd0);

        // Scenario 2: reprogram siren-on to 2 s, then reset restores 10 s.
        step(1'b0, 2'd0, 1'b1, 2'd3, 4'd2);
        step(1'b1, 2'd3, 1'b0, 2'd0, 4'd0);
        run_until_expired(k);
        chk("s2_short", k, 8);
        idle(2);
        do_reset();
        step(1'b1, 2'd3, 1'b0, 2'd0, 4'd0);
        run_until_expired(k);
        chk("s2_restored", k, 40);
        idle(2);

        // Scenario 3: restart with arm delay at cycle 20 of a passenger countdown.
        step(1'b1, 2'd2, 1'b0, 2'd0, 4'd0);
        idle(19);
        step(1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        run_until_expired(k);
        chk("s3_restart", k, 24);
        idle(20);

        // Scenario 4: write beats start in the same cycle.
        step(1'b1, 2'd0, 1'b1, 2'd0, 4'd5);
        chk("s4_idle", {31'd0, busy}, 32'd0);
        idle(40);
        step(1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        run_until_expired(k);
        chk("s4_written", k, 20);

        // Scenario 5: zero-length arm delay.
        step(1'b0, 2'd0, 1'b1, 2'd0, 4'd0);
        idle(2);
        step(1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        chk("s5_expired", {31'd0, expired}, 32'd1);
        idle(10);

        // Scenario 6: reset mid-countdown.
        step(1'b1, 2'd3, 1'b0, 2'd0, 4'd0);
        idle(10);
        do_reset();
        idle(60);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                step(1'b0, 2'($urandom), 1'b1, 2'($urandom), 4'($urandom));
            end else if (r < 8) begin
                step(1'b1, 2'($urandom), 1'b0, 2'd0, 4'd0);
            end else if (r < 9) begin
                step(1'b1, 2'($urandom), 1'b1, 2'($urandom), 4'($urandom));
            end else begin
                idle(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
